fft_input_loader: RTL and testbench

Upstream feeder for the FFT core. Accepts one frame of `N_SAMPLES` complex samples over a valid/ready stream and writes each into the FFT working RAM (mem0) at its bit-reversed address. After the last sample is committed it pulses `fft_start`. It then holds off new input until the core raises `fft_finish`, and re-arms for the next frame.

---
 rtl/fft_input_loader_if.sv | 30 +++
 rtl/fft_input_loader.sv | 103 ++++++++++
 tb/tb_fft_input_loader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_input_loader_if.sv
// Stream, RAM-write and core-control signals shared between the FFT input
// loader (slave) and whatever drives it (master).
interface fft_input_loader_if #(
  parameter int N_SAMPLES  = 8,
  parameter int DATA_WIDTH = 16
);
  localparam int AW = $clog2(N_SAMPLES);

  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_re;
  logic [DATA_WIDTH-1:0]   in_im;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [2*DATA_WIDTH-1:0] wr_data;
  logic                    fft_start;
  logic                    fft_finish;
  logic                    busy;
  logic [15:0]             frame_cnt;

  modport master (
    output in_valid, in_re, in_im, fft_finish,
    input  in_ready, wr_en, wr_addr, wr_data, fft_start, busy, frame_cnt
  );

  modport slave (
    input  in_valid, in_re, in_im, fft_finish,
    output in_ready, wr_en, wr_addr, wr_data, fft_start, busy, frame_cnt
  );
endinterface

// File: rtl/fft_input_loader.sv
// FFT input loader: collects one frame of complex samples, writes each to
// the working RAM at its bit-reversed index, kicks the core with a one-cycle
// start pulse and blocks new input until the core reports completion.
module fft_input_loader #(
  parameter int N_SAMPLES  = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  fft_input_loader_if.slave  bus
);
  localparam int AW = $clog2(N_SAMPLES);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_SAMPLES - 1);

  typedef enum logic [1:0] {S_LOAD, S_FLUSH, S_START, S_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [AW-1:0]           idx_rev;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    wr_en_q, wr_en_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [2*DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                    fft_start_q, fft_start_d;
  logic                    handshake;

  // Mirror the sample index bit order to get the RAM address.
  for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
    assign idx_rev[gi] = idx_q[AW-1-gi];
  end

  // in_ready is registered, so a handshake depends only on the current state.
  assign handshake = (state_q == S_LOAD) && in_ready_q && bus.in_valid;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (handshake) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_rev;
          wr_data_d = {bus.in_re, bus.in_im};
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_FLUSH;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      S_FLUSH: state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.fft_finish) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
    // Start pulse lands in the START cycle, after the last write has issued.
    fft_start_d = (state_q == S_FLUSH);
    in_ready_d  = (state_d == S_LOAD);
  end

  // State and registered outputs; reset abandons any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fft_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      fft_start_q <= fft_start_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.fft_start = fft_start_q;
  assign bus.busy      = (state_q != S_LOAD);
  assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard bench for fft_input_loader: a cycle-level reference model
// predicts writes and control outputs, a negedge monitor compares.
module tb_fft_input_loader;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fft_input_loader_if #(.N_SAMPLES(N), .DATA_WIDTH(DW)) bus();

  fft_input_loader #(.N_SAMPLES(N), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int              stamp;
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  // Reference model state.
  int          n         = 0;
  bit          loading   = 1'b1;
  int          cnt       = 0;
  int          done_edge = -100;
  logic [15:0] m_frame   = '0;
  bit          exp_ready = 1'b0;
  bit          exp_start = 1'b0;
  bit          exp_busy  = 1'b0;
  logic [AW-1:0]   last_addr = '0;
  logic [2*DW-1:0] last_data = '0;

  function automatic int rev(int v);
    int r = 0;
    for (int k = 0; k < AW; k++) r = (r << 1) | ((v >> k) & 1);
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, n);
    end
  endtask

  // Model: the k-th accepted sample of a frame goes to rev(k) one cycle later;
  // start pulse two cycles after the last acceptance; finish counts only from
  // the third edge after the last acceptance onward.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        n = 0; loading = 1'b1; cnt = 0; done_edge = -100; m_frame = '0;
        exp_ready = 1'b0; exp_start = 1'b0; exp_busy = 1'b0;
        exp_q.delete(); last_addr = '0; last_data = '0;
      end else begin
        n++;
        if (loading) begin
          if (exp_ready && bus.in_valid) begin
            wr_t e;
            e.stamp = n;
            e.addr  = AW'(rev(cnt));
            e.data  = {bus.in_re, bus.in_im};
            exp_q.push_back(e);
            cnt++;
            if (cnt == N) begin
              loading = 1'b0; done_edge = n; cnt = 0;
            end
          end
        end else if (n >= done_edge + 3 && bus.fft_finish) begin
          loading = 1'b1;
          m_frame++;
        end
        exp_ready = loading;
        exp_busy  = !loading;
        exp_start = !loading && (n == done_edge + 1);
      end
    end
  end

  // Monitor: compare DUT outputs with the model away from the active edge.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        chk("busy", 32'(bus.busy), 32'(exp_busy));
        chk("fft_start", 32'(bus.fft_start), 32'(exp_start));
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_frame));
        if (bus.wr_en) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL wr_unexpected: got wr_en=1 addr=%0d expected no write (edge %0d)",
                     bus.wr_addr, n);
          end else begin
            e = exp_q.pop_front();
            if (e.stamp != n || e.addr !== bus.wr_addr || e.data !== bus.wr_data) begin
              fails++;
              $display("FAIL wr_check: got addr=%0d data=%08h edge=%0d expected addr=%0d data=%08h edge=%0d",
                       bus.wr_addr, bus.wr_data, n, e.addr, e.data, e.stamp);
            end
            last_addr = e.addr;
            last_data = e.data;
          end
        end else begin
          tests++;
          if (exp_q.size() > 0 && exp_q[0].stamp <= n) begin
            fails++;
            $display("FAIL wr_missing: got wr_en=0 expected write addr=%0d (edge %0d)",
                     exp_q[0].addr, n);
            void'(exp_q.pop_front());
          end
          chk("wr_addr_hold", 32'(bus.wr_addr), 32'(last_addr));
          chk("wr_data_hold", 32'(bus.wr_data), 32'(last_data));
        end
      end
    end
  end

  task automatic idle(int k);
    bus.in_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic send(logic [DW-1:0] re, logic [DW-1:0] im);
    bit r;
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_re    = re;
    bus.in_im    = im;
    for (int c = 0; c < 200; c++) begin
      r = bus.in_ready;
      @(negedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL send_timeout: got no acceptance expected acceptance within 200 cycles");
    end
  endtask

  // mode 0: back-to-back, 1: two idle cycles between samples, 2: random gaps.
  task automatic send_frame(int mode, bit rnd);
    for (int i = 0; i < N; i++) begin
      if (i > 0 && mode == 1) idle(2);
      if (i > 0 && mode == 2) idle(int'($urandom_range(0, 3)));
      if (rnd) send(DW'($urandom), DW'($urandom));
      else     send(DW'(i), DW'(-i));
    end
  endtask

  // Wait for the start pulse, then raise finish d cycles later, optionally
  // holding it high; bp keeps in_valid asserted during the wait.
  task automatic finish_after(int d, bit hold, bit bp);
    bit seen = 1'b0;
    bus.in_valid = bp;
    bus.in_re    = DW'($urandom);
    bus.in_im    = DW'($urandom);
    for (int c = 0; c < 20; c++) begin
      if (bus.fft_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL start_timeout: got no fft_start expected one within 20 cycles");
    end
    repeat (d) @(negedge clk);
    bus.fft_finish = 1'b1;
    @(negedge clk);
    if (!hold) bus.fft_finish = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  // Assert reset mid-cycle and check every output clears without a clock edge.
  task automatic reset_check();
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_fft_start", 32'(bus.fft_start), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    bus.in_valid   = 1'b0;
    bus.fft_finish = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_re      = '0;
    bus.in_im      = '0;
    bus.fft_finish = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Back-to-back frame with re=i, im=-i, then 20-cycle wait under backpressure.
    send_frame(0, 1'b0);
    finish_after(20, 1'b0, 1'b1);
    $display("[TB] frame: back-to-back, frame_cnt=%0d", bus.frame_cnt);

    // Bubbles between samples.
    send_frame(1, 1'b0);
    finish_after(1, 1'b0, 1'b0);
    $display("[TB] frame: bubbles, frame_cnt=%0d", bus.frame_cnt);

    // Finish held high through the following frame's load.
    send_frame(0, 1'b1);
    finish_after(3, 1'b1, 1'b1);
    send_frame(2, 1'b1);
    finish_after(2, 1'b0, 1'b0);
    $display("[TB] frame: stale finish, frame_cnt=%0d", bus.frame_cnt);

    // Reset after five samples, then a fresh frame.
    for (int i = 0; i < 5; i++) send(DW'(100 + i), DW'(200 + i));
    reset_check();
    send_frame(0, 1'b0);
    finish_after(1, 1'b0, 1'b0);
    $display("[TB] frame: after mid-load reset, frame_cnt=%0d", bus.frame_cnt);

    // Randomized frames; one is abandoned by a reset while waiting.
    for (int f = 0; f < 8; f++) begin
      send_frame(2, 1'b1);
      if (f == 3) begin
        repeat (4) @(negedge clk);
        reset_check();
        $display("[TB] frame: random %0d abandoned by reset in WAIT", f);
      end else begin
        finish_after(int'($urandom_range(1, 6)), 1'b0, 1'($urandom_range(0, 1)));
        $display("[TB] frame: random %0d, frame_cnt=%0d", f, bus.frame_cnt);
      end
    end

    idle(4);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
